// File: rtl/hack_rom_loader.sv
// rtl/hack_rom_loader.sv - framed byte-stream boot loader for the Hack instruction ROM
//
// Receives LEN(16b) | N payload words | CSUM(16b), all as big-endian byte pairs,
// and writes each payload word into the instruction ROM write port. The CPU stays
// in reset (cpu_hold=1) until a complete image with a matching checksum is stored.
//
// Ports:
//   Clk          clock, all state on rising edge
//   Reset        asynchronous, active-low reset
//   start        1-cycle pulse, begins a new load from IDLE/DONE/ERROR
//   in_valid     stream byte valid
//   in_data      stream byte
//   in_ready     loader accepts a byte this cycle
//   rom_we       ROM write strobe, one cycle per word
//   rom_addr     ROM write address (holds when rom_we=0)
//   rom_wdata    ROM write data
//   cpu_hold     active-high CPU reset
//   busy         load in progress
//   done         image stored and verified (sticky until next start)
//   error        bad length or checksum (sticky until next start)
//   words_loaded words written in the current/last load
module hack_rom_loader #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_W     = 10,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM_HI,
        S_CSUM_LO,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              load_q;
    logic [7:0]        hi_byte;
    logic [15:0]       sum;
    logic [ADDR_W:0]   len_q;
    logic              accept;
    logic              start_ok;
    logic [15:0]       rx_word;
    logic [ADDR_W:0]   words_next;
    logic              next_is_load;

    // The handshake flags are registered from next_state, so they read 0 while
    // Reset is asserted and come up one edge after release.
    assign in_ready   = load_q;
    assign busy       = load_q;
    assign accept     = in_valid & load_q;
    assign rx_word    = {hi_byte, in_data};
    assign words_next = words_loaded + (ADDR_W+1)'(1);
    assign start_ok   = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) next_state = S_LEN_HI;
            S_LEN_HI:  if (accept) next_state = S_LEN_LO;
            S_LEN_LO: begin
                if (accept) begin
                    if ((rx_word == 16'd0) || ({16'd0, rx_word} > 32'(DEPTH)))
                        next_state = S_ERROR;
                    else
                        next_state = S_DATA_HI;
                end
            end
            S_DATA_HI: if (accept) next_state = S_DATA_LO;
            S_DATA_LO: begin
                if (accept) next_state = (words_next == len_q) ? S_CSUM_HI : S_DATA_HI;
            end
            S_CSUM_HI: if (accept) next_state = S_CSUM_LO;
            S_CSUM_LO: begin
                if (accept) next_state = (rx_word == sum) ? S_DONE : S_ERROR;
            end
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        next_is_load = 1'b0;
        case (next_state)
            S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM_HI, S_CSUM_LO: next_is_load = 1'b1;
            default: next_is_load = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state        <= AUTO_START ? S_LEN_HI : S_IDLE;
            load_q       <= 1'b0;
            hi_byte      <= 8'd0;
            sum          <= 16'd0;
            len_q        <= '0;
            rom_we       <= 1'b0;
            rom_addr     <= '0;
            rom_wdata    <= 16'd0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state    <= next_state;
            load_q   <= next_is_load;
            done     <= (next_state == S_DONE);
            error    <= (next_state == S_ERROR);
            cpu_hold <= (next_state != S_DONE);
            rom_we   <= 1'b0;

            if (start_ok) begin
                words_loaded <= '0;
                sum          <= 16'd0;
                rom_addr     <= '0;
            end

            if (accept) begin
                case (state)
                    S_LEN_HI, S_DATA_HI, S_CSUM_HI: hi_byte <= in_data;
                    // Only a legal length reaches DATA_HI, so the truncation is lossless there.
                    S_LEN_LO: len_q <= rx_word[ADDR_W:0];
                    S_DATA_LO: begin
                        rom_we       <= 1'b1;
                        rom_addr     <= words_loaded[ADDR_W-1:0];
                        rom_wdata    <= rx_word;
                        words_loaded <= words_next;
                        sum          <= sum + rx_word;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb/tb_hack_rom_loader.sv - self-checking bench for hack_rom_loader
module tb_hack_rom_loader;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    hack_rom_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .AUTO_START(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    wr_t  wr_q[$];
    int   acc_cyc[$];

    always @(posedge Clk) cyc <= cyc + 1;

    // Write monitor: records every strobe together with the edge that produced it.
    always @(negedge Clk) begin
        if (rom_we === 1'b1) wr_q.push_back('{cyc, 32'(rom_addr), rom_wdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives bytes with a pvalid% chance of in_valid per cycle; records the edge index
    // on which each byte is accepted. start is raised alongside byte start_idx.
    task automatic send_bytes(input logic [7:0] b[$], input int pvalid, input int start_idx);
        acc_cyc.delete();
        foreach (b[i]) begin
            int  waited = 0;
            bit  got = 0;
            while (!got) begin
                @(negedge Clk);
                in_data  = b[i];
                in_valid = ($urandom_range(99) < pvalid);
                start    = (i == start_idx) && (waited == 0);
                if (in_valid && in_ready) begin
                    got = 1;
                    acc_cyc.push_back(cyc + 1);
                end
                waited++;
                if (!got && waited > 400) begin
                    chk("stall_timeout", 32'd0, 32'd1);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        @(negedge Clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // Reference model: a frame is valid when 1<=N<=DEPTH; each payload word k is
    // written to address k one cycle after its low byte; done iff csum matches the
    // 16-bit wrap-around sum of the payload.
    task automatic run_load(input logic [15:0] words[$], input logic [15:0] n,
                            input logic [15:0] csum, input int pvalid, input int start_idx);
        logic [7:0]  b[$];
        logic [15:0] s = 16'd0;
        bit          len_ok = (n != 16'd0) && (int'(n) <= DEPTH);
        bit          exp_done;
        int          exp_w;
        b.push_back(n[15:8]);
        b.push_back(n[7:0]);
        if (len_ok) begin
            foreach (words[k]) begin
                b.push_back(words[k][15:8]);
                b.push_back(words[k][7:0]);
                s = s + words[k];
            end
            b.push_back(csum[15:8]);
            b.push_back(csum[7:0]);
        end
        exp_done = len_ok && (csum == s);
        exp_w    = len_ok ? int'(n) : 0;
        wr_q.delete();
        send_bytes(b, pvalid, start_idx);
        @(negedge Clk);
        chk("write_count", wr_q.size(), exp_w);
        for (int k = 0; k < wr_q.size() && k < exp_w; k++) begin
            chk($sformatf("wr%0d_addr", k), wr_q[k].addr, k);
            chk($sformatf("wr%0d_data", k), 32'(wr_q[k].data), 32'(words[k]));
            if (2 + 2*k + 1 < acc_cyc.size())
                chk($sformatf("wr%0d_latency", k), wr_q[k].cyc, acc_cyc[2 + 2*k + 1]);
        end
        chk("done", 32'(done), 32'(exp_done));
        chk("error", 32'(error), 32'(!exp_done));
        chk("cpu_hold", 32'(cpu_hold), 32'(!exp_done));
        chk("words_loaded", 32'(words_loaded), exp_w);
        chk("in_ready_end", 32'(in_ready), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_err_clr", 32'(error), 32'd0);
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_words_clr", 32'(words_loaded), 32'd0);
    endtask

    initial begin
        logic [15:0] img[$];
        logic [15:0] big[$];
        logic [7:0]  part[$];
        logic [15:0] bsum;

        img = '{16'hEC10, 16'hE308, 16'h0005};

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_rom_we", 32'(rom_we), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_rom_wdata", 32'(rom_wdata), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        Reset = 1'b1;

        // Good image, auto-started
        run_load(img, 16'd3, 16'hCF1D, 100, -1);

        // Bad checksum
        pulse_start();
        run_load(img, 16'd3, 16'h0000, 100, -1);

        // Illegal lengths
        pulse_start();
        run_load(img, 16'd0, 16'h0000, 100, -1);
        pulse_start();
        run_load(img, 16'h0401, 16'h0000, 100, -1);

        // Random in_valid gaps
        pulse_start();
        run_load(img, 16'd3, 16'hCF1D, 50, -1);

        // Reset partway through a load, then resend
        pulse_start();
        part = '{8'h00, 8'h03, 8'hEC, 8'h10, 8'hE3, 8'h08};
        send_bytes(part, 100, -1);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midrst_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_we", 32'(rom_we), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_words", 32'(words_loaded), 32'd0);
        @(negedge Clk);
        Reset = 1'b1;
        run_load(img, 16'd3, 16'hCF1D, 100, -1);

        // start during a load is ignored
        pulse_start();
        run_load(img, 16'd3, 16'hCF1D, 70, 5);

        // Full-depth random image started from DONE
        bsum = 16'd0;
        for (int k = 0; k < DEPTH; k++) begin
            big.push_back(16'($urandom));
            bsum = bsum + big[k];
        end
        pulse_start();
        run_load(big, 16'(DEPTH), bsum, 90, -1);
        if (wr_q.size() > 0) chk("last_addr", wr_q[wr_q.size()-1].addr, 32'h3FF);
        else chk("last_addr_present", 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
